multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26], stable from DECODE onward.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory handshake; an access completes in a cycle with mem_ready=1.
REQ-007 pc_en  output  1  PC load enable, computed as pc_write OR (pc_write_cond AND zero).
REQ-008 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, i_or_d, alu_src_a  outputs  1 each  datapath controls.
REQ-009 alu_src_b, alu_op, pc_source  outputs  2 each  datapath selects.
REQ-010 ext_mode  output  2  immediate extender mode: 00 sign, 01 zero, 10 upper (imm<<16).
REQ-011 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 retired  output  CNT_W  count of completed instructions.
REQ-013 state  output  4  current state, for debug.

Function
REQ-014 Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, lui 001111.
REQ-015 States/encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11; codes 12-15 go to FETCH on the next edge.
REQ-016 Transitions: FETCH->DECODE when mem_ready, else hold. DECODE->MEM_ADDR (lw/sw), EXEC_R, BRANCH, JUMP, EXEC_I (addi/andi/ori/lui), else FETCH. MEM_ADDR->MEM_RD (lw) or MEM_WR (sw). MEM_RD->MEM_WB when mem_ready, else hold. MEM_WR->FETCH when mem_ready, else hold. EXEC_R->R_WB. EXEC_I->I_WB. MEM_WB, R_WB, I_WB, BRANCH, JUMP->FETCH.
REQ-017 Outputs are Moore, decoded from state (plus opcode for ext_mode, mem_ready for gated strobes); every control not listed for a state is 0.
REQ-018 FETCH: mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
REQ-019 DECODE: alu_src_b=11, alu_op=00, ext_mode=00.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_mode=00.
REQ-021 MEM_RD: mem_read=1, i_or_d=1. MEM_WR: mem_write=1, i_or_d=1 (held until mem_ready).
REQ-022 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. R_WB: reg_write=1, reg_dst=1. I_WB: reg_write=1, reg_dst=0.
REQ-023 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-024 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11; ext_mode=01 for andi/ori, 10 for lui, 00 for addi.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. JUMP: pc_write=1, pc_source=10.
REQ-026 illegal=1 only in DECODE with unsupported opcode; no register or memory write occurs for it.
REQ-027 retired increments by 1 on each edge leaving MEM_WB, R_WB, I_WB, BRANCH, JUMP, or MEM_WR with mem_ready=1; wraps from all-ones to 0; illegal opcodes do not count.
REQ-028 Latencies with mem_ready always 1: R/addi/andi/ori/lui 4 cycles, lw 5, sw 4, beq 3, j 3.

Reset
REQ-029 rst=1 forces state=FETCH and retired=0 immediately, regardless of clk; outputs take FETCH values; reset mid-instruction abandons it uncounted.
REQ-030 On rst deassertion, the first edge evaluates FETCH normally.

Structure
REQ-031 Shared package cpu_ctrl_pkg holds state codes, opcode constants, ext_mode and alu_op encodings.
REQ-032 One sub-module, opcode_class, maps opcode to {is_r, is_lw, is_sw, is_beq, is_j, is_imm, illegal, ext_mode}.

Verification
REQ-033 addi, mem_ready=1: states 0,1,10,11,0; ext_mode=00 in state 10; retired 0->1.
REQ-034 lw with mem_ready low 3 cycles in MEM_RD: state 3 held 4 cycles, mem_read=1, i_or_d=1, reg_write=0 until MEM_WB.
REQ-035 beq with zero=1 then zero=0: pc_en=1 then 0 in BRANCH; retired counts both.
REQ-036 opcode 111111: illegal pulses one cycle, DECODE->FETCH, retired unchanged, no write strobes.
REQ-037 rst asserted mid-EXEC_I (asynchronously, between edges): state=0, retired=0 before next edge.
REQ-038 CNT_W=4, 16 R-type instructions: retired wraps 15->0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg -- shared definitions for the multicycle CPU controller.
// Holds the controller state codes, the supported opcode values, the
// immediate-extender modes, the ALU operation classes and the datapath
// select encodings used by multicycle_ctrl and opcode_class.
package cpu_ctrl_pkg;

    // Controller states; codes 12-15 are unused and recover to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    // Opcode field IR[31:26] of the supported instructions.
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    // Immediate extender modes.
    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    // ALU operation classes handed to the ALU control decoder.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    // ALU B-operand selects.
    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_BOFS = 2'b11;

    // Next-PC source selects.
    localparam logic [1:0] PC_SRC_ALU  = 2'b00;
    localparam logic [1:0] PC_SRC_OUT  = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// opcode_class -- combinational classifier for the instruction opcode.
// Ports:
//   opcode   in  6  IR[31:26]
//   is_r, is_lw, is_sw, is_beq, is_j, is_imm  out  instruction class flags
//   illegal  out  1  opcode is not one of the supported instructions
//   ext_mode out  2  immediate extender mode for the I-type ALU ops
module opcode_class
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_r,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_j,
    output logic       is_imm,
    output logic       illegal,
    output logic [1:0] ext_mode
);

    // Opcode to class flags and extender mode; anything unlisted is illegal.
    always_comb begin
        is_r     = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_j     = 1'b0;
        is_imm   = 1'b0;
        illegal  = 1'b0;
        ext_mode = EXT_SIGN;
        case (opcode)
            OP_R:    is_r   = 1'b1;
            OP_LW:   is_lw  = 1'b1;
            OP_SW:   is_sw  = 1'b1;
            OP_BEQ:  is_beq = 1'b1;
            OP_J:    is_j   = 1'b1;
            OP_ADDI: is_imm = 1'b1;
            OP_ANDI: begin
                is_imm   = 1'b1;
                ext_mode = EXT_ZERO;
            end
            OP_ORI: begin
                is_imm   = 1'b1;
                ext_mode = EXT_ZERO;
            end
            OP_LUI: begin
                is_imm   = 1'b1;
                ext_mode = EXT_UPPER;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- Moore FSM controller for a multicycle MIPS-like datapath.
// Ports:
//   clk, rst            in   clock, asynchronous active-high reset
//   opcode              in   IR[31:26], stable from DECODE onward
//   zero                in   ALU zero flag (qualifies pc_write_cond)
//   mem_ready           in   memory handshake; access completes when high
//   pc_en               out  pc_write | (pc_write_cond & zero)
//   pc_write .. alu_src_a  out  single-bit datapath controls
//   alu_src_b, alu_op, pc_source, ext_mode  out  2-bit datapath selects
//   illegal             out  one-cycle pulse in DECODE on an unsupported opcode
//   retired             out  CNT_W-bit count of completed instructions (wraps)
//   state               out  current state code, for debug
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             i_or_d,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [1:0]       ext_mode,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] retired_r;
    logic             retire_s;

    logic       is_r_s;
    logic       is_lw_s;
    logic       is_sw_s;
    logic       is_beq_s;
    logic       is_j_s;
    logic       is_imm_s;
    logic       cls_illegal_s;
    logic [1:0] cls_ext_s;

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .is_r     (is_r_s),
        .is_lw    (is_lw_s),
        .is_sw    (is_sw_s),
        .is_beq   (is_beq_s),
        .is_j     (is_j_s),
        .is_imm   (is_imm_s),
        .illegal  (cls_illegal_s),
        .ext_mode (cls_ext_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state logic and the retire strobe (instruction leaves its last state).
    always_comb begin
        next_state_s = S_FETCH;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_lw_s || is_sw_s) begin
                    next_state_s = S_MEM_ADDR;
                end else if (is_r_s) begin
                    next_state_s = S_EXEC_R;
                end else if (is_beq_s) begin
                    next_state_s = S_BRANCH;
                end else if (is_j_s) begin
                    next_state_s = S_JUMP;
                end else if (is_imm_s) begin
                    next_state_s = S_EXEC_I;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                if (is_lw_s) begin
                    next_state_s = S_MEM_RD;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_EXEC_R: next_state_s = S_R_WB;
            S_EXEC_I: next_state_s = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            default: next_state_s = S_FETCH;
        endcase
    end

    // Moore output decode; controls not named for a state stay 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        i_or_d        = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_ADD;
        pc_source     = PC_SRC_ALU;
        ext_mode      = EXT_SIGN;
        illegal       = 1'b0;
        case (state_r)
            S_FETCH: begin
                // PC+4 and IR load only land once the fetch completes.
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_BOFS;
                illegal   = cls_illegal_s;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_OUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_IMM;
                ext_mode  = cls_ext_s;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign retired = retired_r;
    assign state   = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- table-driven bench for multicycle_ctrl (CNT_W=4).
// Each table row is one clock cycle: the inputs driven for that cycle and
// the state, control word and retired count expected during it.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, pc_write, pc_write_cond, ir_write, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, i_or_d, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source, ext_mode;
    logic [3:0] retired;
    logic [3:0] state;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .ext_mode(ext_mode),
        .illegal(illegal), .retired(retired), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {pc_en pc_write pc_write_cond ir_write mem_read mem_write
    //  reg_write reg_dst mem_to_reg i_or_d alu_src_a | alu_src_b alu_op
    //  pc_source ext_mode | illegal}
    logic [19:0] ctl;
    assign ctl = {pc_en, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                  reg_write, reg_dst, mem_to_reg, i_or_d, alu_src_a,
                  alu_src_b, alu_op, pc_source, ext_mode, illegal};

    localparam logic [19:0] C_FETCH   = 20'b11011000000_01_00_00_00_0;
    localparam logic [19:0] C_FETCH_W = 20'b00001000000_01_00_00_00_0;
    localparam logic [19:0] C_DEC     = 20'b00000000000_11_00_00_00_0;
    localparam logic [19:0] C_DEC_ILL = 20'b00000000000_11_00_00_00_1;
    localparam logic [19:0] C_MADDR   = 20'b00000000001_10_00_00_00_0;
    localparam logic [19:0] C_MRD     = 20'b00001000010_00_00_00_00_0;
    localparam logic [19:0] C_MWB     = 20'b00000010100_00_00_00_00_0;
    localparam logic [19:0] C_MWR     = 20'b00000100010_00_00_00_00_0;
    localparam logic [19:0] C_EXR     = 20'b00000000001_00_10_00_00_0;
    localparam logic [19:0] C_RWB     = 20'b00000011000_00_00_00_00_0;
    localparam logic [19:0] C_EXI_S   = 20'b00000000001_10_11_00_00_0;
    localparam logic [19:0] C_EXI_Z   = 20'b00000000001_10_11_00_01_0;
    localparam logic [19:0] C_EXI_U   = 20'b00000000001_10_11_00_10_0;
    localparam logic [19:0] C_IWB     = 20'b00000010000_00_00_00_00_0;
    localparam logic [19:0] C_BR_T    = 20'b10100000001_00_01_01_00_0;
    localparam logic [19:0] C_BR_N    = 20'b00100000001_00_01_01_00_0;
    localparam logic [19:0] C_JMP     = 20'b11000000000_00_00_10_00_0;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] LUI  = 6'b001111;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [19:0] c;
        logic [3:0]  ret;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    task automatic add(input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [19:0] c, input logic [3:0] ret);
        vec_t v;
        v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.c = c; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        opcode = ADDI;
        zero = 1'b0;
        mem_ready = 1'b1;

        // addi, all ready
        add(ADDI, 1'b0, 1'b1, 4'd0,  C_FETCH,   4'd0);
        add(ADDI, 1'b0, 1'b1, 4'd1,  C_DEC,     4'd0);
        add(ADDI, 1'b0, 1'b1, 4'd10, C_EXI_S,   4'd0);
        add(ADDI, 1'b0, 1'b1, 4'd11, C_IWB,     4'd0);
        // lw with three wait cycles in MEM_RD
        add(LW,   1'b0, 1'b1, 4'd0,  C_FETCH,   4'd1);
        add(LW,   1'b0, 1'b1, 4'd1,  C_DEC,     4'd1);
        add(LW,   1'b0, 1'b1, 4'd2,  C_MADDR,   4'd1);
        add(LW,   1'b0, 1'b0, 4'd3,  C_MRD,     4'd1);
        add(LW,   1'b0, 1'b0, 4'd3,  C_MRD,     4'd1);
        add(LW,   1'b0, 1'b0, 4'd3,  C_MRD,     4'd1);
        add(LW,   1'b0, 1'b1, 4'd3,  C_MRD,     4'd1);
        add(LW,   1'b0, 1'b1, 4'd4,  C_MWB,     4'd1);
        // beq taken then not taken
        add(BEQ,  1'b1, 1'b1, 4'd0,  C_FETCH,   4'd2);
        add(BEQ,  1'b1, 1'b1, 4'd1,  C_DEC,     4'd2);
        add(BEQ,  1'b1, 1'b1, 4'd8,  C_BR_T,    4'd2);
        add(BEQ,  1'b0, 1'b1, 4'd0,  C_FETCH,   4'd3);
        add(BEQ,  1'b0, 1'b1, 4'd1,  C_DEC,     4'd3);
        add(BEQ,  1'b0, 1'b1, 4'd8,  C_BR_N,    4'd3);
        // unsupported opcode: DECODE -> FETCH, not counted
        add(BAD,  1'b0, 1'b1, 4'd0,  C_FETCH,   4'd4);
        add(BAD,  1'b0, 1'b1, 4'd1,  C_DEC_ILL, 4'd4);
        // sw with a fetch stall and a write stall
        add(SW,   1'b0, 1'b0, 4'd0,  C_FETCH_W, 4'd4);
        add(SW,   1'b0, 1'b1, 4'd0,  C_FETCH,   4'd4);
        add(SW,   1'b0, 1'b1, 4'd1,  C_DEC,     4'd4);
        add(SW,   1'b0, 1'b1, 4'd2,  C_MADDR,   4'd4);
        add(SW,   1'b0, 1'b0, 4'd5,  C_MWR,     4'd4);
        add(SW,   1'b0, 1'b1, 4'd5,  C_MWR,     4'd4);
        // j
        add(J,    1'b0, 1'b1, 4'd0,  C_FETCH,   4'd5);
        add(J,    1'b0, 1'b1, 4'd1,  C_DEC,     4'd5);
        add(J,    1'b0, 1'b1, 4'd9,  C_JMP,     4'd5);
        // R-type
        add(R,    1'b0, 1'b1, 4'd0,  C_FETCH,   4'd6);
        add(R,    1'b0, 1'b1, 4'd1,  C_DEC,     4'd6);
        add(R,    1'b0, 1'b1, 4'd6,  C_EXR,     4'd6);
        add(R,    1'b0, 1'b1, 4'd7,  C_RWB,     4'd6);
        // andi / ori / lui extender modes
        add(ANDI, 1'b0, 1'b1, 4'd0,  C_FETCH,   4'd7);
        add(ANDI, 1'b0, 1'b1, 4'd1,  C_DEC,     4'd7);
        add(ANDI, 1'b0, 1'b1, 4'd10, C_EXI_Z,   4'd7);
        add(ANDI, 1'b0, 1'b1, 4'd11, C_IWB,     4'd7);
        add(ORI,  1'b0, 1'b1, 4'd0,  C_FETCH,   4'd8);
        add(ORI,  1'b0, 1'b1, 4'd1,  C_DEC,     4'd8);
        add(ORI,  1'b0, 1'b1, 4'd10, C_EXI_Z,   4'd8);
        add(ORI,  1'b0, 1'b1, 4'd11, C_IWB,     4'd8);
        add(LUI,  1'b0, 1'b1, 4'd0,  C_FETCH,   4'd9);
        add(LUI,  1'b0, 1'b1, 4'd1,  C_DEC,     4'd9);
        add(LUI,  1'b0, 1'b1, 4'd10, C_EXI_U,   4'd9);
        add(LUI,  1'b0, 1'b1, 4'd11, C_IWB,     4'd9);
        add(R,    1'b0, 1'b1, 4'd0,  C_FETCH,   4'd10);

        // Reset state
        #1;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_retired", {28'd0, retired}, 32'd0);
        check("reset_ctl", {12'd0, ctl}, {12'd0, C_FETCH});

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op;
            zero = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("row%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
            check($sformatf("row%0d_ctl", i), {12'd0, ctl}, {12'd0, vecs[i].c});
            check($sformatf("row%0d_retired", i), {28'd0, retired}, {28'd0, vecs[i].ret});
            @(negedge clk);
        end

        // Asynchronous reset in the middle of EXEC_I
        opcode = ADDI;
        mem_ready = 1'b1;
        #1;
        check("pre_rst_decode", {28'd0, state}, 32'd1);
        @(posedge clk);
        #2;
        check("pre_rst_exec_i", {28'd0, state}, 32'd10);
        rst = 1'b1;
        #1;
        check("async_rst_state", {28'd0, state}, 32'd0);
        check("async_rst_retired", {28'd0, retired}, 32'd0);
        check("async_rst_ctl", {12'd0, ctl}, {12'd0, C_FETCH});
        @(negedge clk);
        @(negedge clk);
        check("held_rst_state", {28'd0, state}, 32'd0);
        rst = 1'b0;

        // 16 R-type instructions: counter wraps 15 -> 0
        opcode = R;
        zero = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check("wrap_retired_15", {28'd0, retired}, 32'd15);
        check("wrap_state_15", {28'd0, state}, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("wrap_retired_0", {28'd0, retired}, 32'd0);
        check("wrap_state_0", {28'd0, state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
